// File: rtl/fta_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fta_bus_pkg
//  Description : Command/response types for the 128-bit fta bus.
//  Revision    : 1.0  initial release
// ============================================================================
package fta_bus_pkg;

  typedef enum logic [4:0] {
    CMD_NONE  = 5'd0,
    CMD_LOAD  = 5'd1,
    CMD_STORE = 5'd2
  } fta_cmd_t;

  typedef struct packed {
    logic [5:0] core;
    logic [2:0] channel;
    logic [3:0] tranid;
  } fta_tranid_t;

  typedef struct packed {
    fta_cmd_t     cmd;
    fta_tranid_t  tid;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  adr;
    logic [127:0] dat;
  } fta_cmd_request128_t;

  typedef struct packed {
    fta_tranid_t  tid;
    logic         ack;
    logic         rty;
    logic         err;
    logic [31:0]  adr;
    logic [127:0] dat;
  } fta_cmd_response128_t;

endpackage
`default_nettype wire

// File: rtl/rf80386_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf80386_pkg
//  Description : Shared types and constants for the rf80386 front end.
//  Revision    : 1.0  initial release
// ============================================================================
package rf80386_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    RETRY = 2'd3
  } icache_state_t;

  localparam int ICACHE_LINE_BYTES = 16;
  localparam int ICACHE_LINE_BITS  = ICACHE_LINE_BYTES * 8;

  // Transaction ids run 1..15; 0 is reserved for "no transaction".
  function automatic logic [3:0] next_tranid(input logic [3:0] t);
    return (t == 4'd15) ? 4'd1 : t + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf80386_icache_bank.sv
`default_nettype none
// ============================================================================
//  Module      : rf80386_icache_bank
//  Description : One direct-mapped bank: valid/tag/data arrays with an
//                asynchronous read port, a synchronous write port and a
//                single-cycle clear of every valid bit (clear beats write).
//  Revision    : 1.0  initial release
// ============================================================================
module rf80386_icache_bank
  import rf80386_pkg::*;
#(
  parameter int LINES = 32,
  parameter int IDX_W = 5,
  parameter int TAG_W = 22
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic [IDX_W-1:0]            rd_idx_i,
  output logic                        rd_valid_o,
  output logic [TAG_W-1:0]            rd_tag_o,
  output logic [ICACHE_LINE_BITS-1:0] rd_data_o,
  input  logic                        we_i,
  input  logic [IDX_W-1:0]            wr_idx_i,
  input  logic [TAG_W-1:0]            wr_tag_i,
  input  logic [ICACHE_LINE_BITS-1:0] wr_data_i
);

  logic [LINES-1:0]            valid_q;
  logic [TAG_W-1:0]            tag_q  [LINES];
  logic [ICACHE_LINE_BITS-1:0] data_q [LINES];

  // Valid bits: reset and invalidate clear all, a fill sets one.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data storage has no reset so it maps onto LUT-RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/rf80386_icache.sv
`default_nettype none
// ============================================================================
//  Module      : rf80386_icache
//  Description : Two-bank line-pair instruction cache. Returns 16 code bytes
//                at any alignment from csip with zero-cycle hit latency;
//                misses are filled over a private fta bus master port.
//                Optional macro RF80386_ICACHE_STATS_EN adds miss/fill
//                counters.
//  Revision    : 1.0  initial release
// ============================================================================
module rf80386_icache
  import fta_bus_pkg::*;
  import rf80386_pkg::*;
#(
  parameter logic [5:0] CORENO         = 6'd1,
  parameter logic [2:0] CID            = 3'd2,
  parameter int         LINES_PER_BANK = 32,
  parameter logic [4:0] RTY_WAIT       = 5'd16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          csip,
  output logic [127:0]         ibundle,
  output logic                 ihit,
  input  logic                 inv_i,
  output logic                 busy_o,
  output fta_cmd_request128_t  ftam_req,
  input  fta_cmd_response128_t ftam_resp
`ifdef RF80386_ICACHE_STATS_EN
  ,
  output logic [31:0]          miss_count_o,
  output logic [31:0]          fill_count_o
`endif
);

  localparam int IDX_W = $clog2(LINES_PER_BANK);
  localparam int TAG_W = 28 - 1 - IDX_W;

  // Line-pair address decode; the +1 wraps modulo 2^28.
  logic [27:0] line_a, line_b, line_even, line_odd;
  assign line_a    = csip[31:4];
  assign line_b    = line_a + 28'd1;
  assign line_even = line_a[0] ? line_b : line_a;
  assign line_odd  = line_a[0] ? line_a : line_b;

  logic                        ev_valid, od_valid;
  logic [TAG_W-1:0]            ev_tag, od_tag;
  logic [ICACHE_LINE_BITS-1:0] ev_data, od_data;
  logic                        hit_even, hit_odd;

  icache_state_t state_q, state_d;
  logic [27:0]   line1_q, line1_d;
  logic [27:0]   line2_q, line2_d;
  logic          pend2_q, pend2_d;
  logic          discard_q, discard_d;
  logic [3:0]    tid_q, tid_d;
  logic [3:0]    cur_tid_q, cur_tid_d;
  logic [4:0]    rcnt_q, rcnt_d;
  logic          fill_we, miss_start, fill_accept, resp_match;

  rf80386_icache_bank #(
    .LINES (LINES_PER_BANK),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_bank_even (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (inv_i),
    .rd_idx_i   (line_even[IDX_W:1]),
    .rd_valid_o (ev_valid),
    .rd_tag_o   (ev_tag),
    .rd_data_o  (ev_data),
    .we_i       (fill_we && !line1_q[0]),
    .wr_idx_i   (line1_q[IDX_W:1]),
    .wr_tag_i   (line1_q[27:IDX_W+1]),
    .wr_data_i  (ftam_resp.dat)
  );

  rf80386_icache_bank #(
    .LINES (LINES_PER_BANK),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_bank_odd (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (inv_i),
    .rd_idx_i   (line_odd[IDX_W:1]),
    .rd_valid_o (od_valid),
    .rd_tag_o   (od_tag),
    .rd_data_o  (od_data),
    .we_i       (fill_we && line1_q[0]),
    .wr_idx_i   (line1_q[IDX_W:1]),
    .wr_tag_i   (line1_q[27:IDX_W+1]),
    .wr_data_i  (ftam_resp.dat)
  );

  assign hit_even = ev_valid && (ev_tag == line_even[27:IDX_W+1]);
  assign hit_odd  = od_valid && (od_tag == line_odd[27:IDX_W+1]);
  assign ihit     = hit_even && hit_odd && !inv_i;

  // Byte-aligned extraction from {hi,lo}; a shift of 128 yields zero.
  logic [127:0] lo_data, hi_data;
  logic [7:0]   shr, shl;
  assign lo_data = line_a[0] ? od_data : ev_data;
  assign hi_data = line_a[0] ? ev_data : od_data;
  assign shr     = {1'b0, csip[3:0], 3'b000};
  assign shl     = 8'd128 - shr;
  assign ibundle = (lo_data >> shr) | (hi_data << shl);

  assign resp_match = (ftam_resp.tid.tranid == cur_tid_q);
  assign busy_o     = (state_q != IDLE);

  logic unused_bits;
  assign unused_bits = ^{ftam_resp.err, ftam_resp.adr, ftam_resp.tid.core,
                         ftam_resp.tid.channel, line_even[0], line_odd[0]};

  // Fill FSM next-state and bus request decode.
  always_comb begin
    state_d     = state_q;
    line1_d     = line1_q;
    line2_d     = line2_q;
    pend2_d     = pend2_q;
    discard_d   = discard_q;
    tid_d       = tid_q;
    cur_tid_d   = cur_tid_q;
    rcnt_d      = rcnt_q;
    fill_we     = 1'b0;
    miss_start  = 1'b0;
    fill_accept = 1'b0;
    ftam_req             = '0;
    ftam_req.cmd         = CMD_NONE;
    ftam_req.tid.core    = CORENO;
    ftam_req.tid.channel = CID;
    case (state_q)
      IDLE: begin
        // An invalidate pulse masks ihit; wait one cycle for valid to clear.
        if (!ihit && !inv_i) begin
          miss_start = 1'b1;
          state_d    = REQ;
          discard_d  = 1'b0;
          if (!hit_even) begin
            line1_d = line_even;
            line2_d = line_odd;
            pend2_d = !hit_odd;
          end else begin
            line1_d = line_odd;
            line2_d = line_odd;
            pend2_d = 1'b0;
          end
        end
      end
      REQ: begin
        ftam_req.cmd        = CMD_LOAD;
        ftam_req.cyc        = 1'b1;
        ftam_req.stb        = 1'b1;
        ftam_req.we         = 1'b0;
        ftam_req.sel        = 16'hFFFF;
        ftam_req.adr        = {line1_q, 4'h0};
        ftam_req.tid.tranid = tid_q;
        cur_tid_d = tid_q;
        tid_d     = next_tranid(tid_q);
        state_d   = WAIT;
        if (inv_i) begin
          discard_d = 1'b1;
          pend2_d   = 1'b0;
        end
      end
      WAIT: begin
        if (ftam_resp.ack && resp_match) begin
          fill_accept = 1'b1;
          fill_we     = !discard_q && !inv_i;
          discard_d   = 1'b0;
          pend2_d     = 1'b0;
          if (pend2_q && !discard_q && !inv_i) begin
            state_d = REQ;
            line1_d = line2_q;
          end else begin
            state_d = IDLE;
          end
        end else if (ftam_resp.rty && resp_match) begin
          if (discard_q || inv_i) begin
            state_d   = IDLE;
            discard_d = 1'b0;
            pend2_d   = 1'b0;
          end else begin
            state_d = RETRY;
            rcnt_d  = '0;
          end
        end else if (inv_i) begin
          discard_d = 1'b1;
          pend2_d   = 1'b0;
        end
      end
      RETRY: begin
        if (inv_i) begin
          state_d = IDLE;
          pend2_d = 1'b0;
        end else if (({1'b0, rcnt_q} + 6'd1) >= {1'b0, RTY_WAIT}) begin
          state_d = REQ;
        end else begin
          rcnt_d = rcnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fill FSM state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      line1_q   <= '0;
      line2_q   <= '0;
      pend2_q   <= 1'b0;
      discard_q <= 1'b0;
      tid_q     <= 4'd1;
      cur_tid_q <= 4'd0;
      rcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      line1_q   <= line1_d;
      line2_q   <= line2_d;
      pend2_q   <= pend2_d;
      discard_q <= discard_d;
      tid_q     <= tid_d;
      cur_tid_q <= cur_tid_d;
      rcnt_q    <= rcnt_d;
    end
  end

`ifdef RF80386_ICACHE_STATS_EN
  logic [31:0] miss_count_q, fill_count_q;

  // Free-running wrap-around miss and fill counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      miss_count_q <= '0;
      fill_count_q <= '0;
    end else begin
      if (miss_start)  miss_count_q <= miss_count_q + 32'd1;
      if (fill_accept) fill_count_q <= fill_count_q + 32'd1;
    end
  end

  assign miss_count_o = miss_count_q;
  assign fill_count_o = fill_count_q;
`else
  logic unused_stats;
  assign unused_stats = miss_start ^ fill_accept;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf80386_icache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf80386_icache
//  Description : Directed self-checking bench for rf80386_icache.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rf80386_icache;
  import fta_bus_pkg::*;

  localparam int RTY_WAIT = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [31:0]          csip;
  logic [127:0]         ibundle;
  logic                 ihit;
  logic                 inv_i;
  logic                 busy_o;
  fta_cmd_request128_t  ftam_req;
  fta_cmd_response128_t ftam_resp;
`ifdef RF80386_ICACHE_STATS_EN
  logic [31:0]          miss_count_o, fill_count_o;
`endif

  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned cyc_cnt     = 0;
  logic [3:0]  exp_tid;
  logic [31:0] exp_adr_q [$];
  logic [127:0] exp_bun_q [$];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  rf80386_icache dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .csip      (csip),
    .ibundle   (ibundle),
    .ihit      (ihit),
    .inv_i     (inv_i),
    .busy_o    (busy_o),
    .ftam_req  (ftam_req),
    .ftam_resp (ftam_resp)
`ifdef RF80386_ICACHE_STATS_EN
    ,
    .miss_count_o (miss_count_o),
    .fill_count_o (fill_count_o)
`endif
  );

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[23:16] ^ a[31:24];
  endfunction

  function automatic logic [127:0] line_data(input logic [31:0] adr);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[k*8 +: 8] = mem_byte({adr[31:4], 4'h0} + 32'(k));
    return d;
  endfunction

  function automatic logic [127:0] bundle_at(input logic [31:0] a);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[k*8 +: 8] = mem_byte(a + 32'(k));
    return d;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_resp(input logic ack, input logic rty, input logic [3:0] t,
                            input logic [127:0] d);
    ftam_resp            = '0;
    ftam_resp.ack        = ack;
    ftam_resp.rty        = rty;
    ftam_resp.tid.core   = 6'd1;
    ftam_resp.tid.channel = 3'd2;
    ftam_resp.tid.tranid = t;
    ftam_resp.dat        = d;
  endtask

  task automatic set_csip(input logic [31:0] a);
    csip = a;
    exp_bun_q.push_back(bundle_at(a));
  endtask

  // Bounded wait for a bus request, checked at the current cycle first.
  task automatic wait_req(output logic found);
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (ftam_req.cyc) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) check("req_timeout", 256'(found), 256'(1));
  endtask

  // Check the next request against the scoreboard and ack it with memory data.
  task automatic fill_one(input string tag);
    logic        found;
    logic [31:0] adr, exp_adr;
    logic [3:0]  t;
    wait_req(found);
    if (found) begin
      adr = ftam_req.adr;
      t   = ftam_req.tid.tranid;
      if (exp_adr_q.size() == 0) begin
        check({tag, "_unexpected_req"}, 256'(adr), 256'hFFFF_FFFF_FFFF);
      end else begin
        exp_adr = exp_adr_q.pop_front();
        check({tag, "_adr"}, 256'(adr), 256'(exp_adr));
      end
      check({tag, "_tid"}, 256'(t), 256'(exp_tid));
      check({tag, "_fields"}, 256'({ftam_req.cmd, ftam_req.stb, ftam_req.we, ftam_req.sel}),
            256'({CMD_LOAD, 1'b1, 1'b0, 16'hFFFF}));
      exp_tid = (exp_tid == 4'd15) ? 4'd1 : exp_tid + 4'd1;
      tick();
      drive_resp(1'b1, 1'b0, t, line_data(adr));
      tick();
      drive_resp(1'b0, 1'b0, 4'd0, '0);
      #1;
    end
  endtask

  task automatic check_hit(input string tag);
    logic [127:0] e;
    #1;
    check({tag, "_ihit"}, 256'(ihit), 256'(1));
    if (exp_bun_q.size() == 0) begin
      check({tag, "_sb_empty"}, 256'(ibundle), 256'(1) << 200);
    end else begin
      e = exp_bun_q.pop_front();
      check({tag, "_bundle"}, 256'(ibundle), 256'(e));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fta_cmd_request128_t rq_reset;
    logic        found;
    logic [3:0]  t1, t2;
    int unsigned rty_cyc;

    rst_i = 1'b1;
    inv_i = 1'b0;
    csip  = 32'h000F_FFF0;
    drive_resp(1'b0, 1'b0, 4'd0, '0);
    repeat (3) tick();

    // Reset state.
    rq_reset = '0;
    rq_reset.tid.core    = 6'd1;
    rq_reset.tid.channel = 3'd2;
    check("rst_ihit", 256'(ihit), 256'(0));
    check("rst_busy", 256'(busy_o), 256'(0));
    check("rst_req", 256'(ftam_req), 256'(rq_reset));

    // 1: cold miss spanning a 64K boundary; even line first.
    rst_i   = 1'b0;
    exp_tid = 4'd1;
    set_csip(32'h000F_FFF0);
    #1;
    check("s1_cold_ihit", 256'(ihit), 256'(0));
    exp_adr_q.push_back(32'h0010_0000);
    exp_adr_q.push_back(32'h000F_FFF0);
    fill_one("s1a");
    fill_one("s1b");
    check("s1_byte0", 256'(ibundle[7:0]), 256'(mem_byte(32'h000F_FFF0)));
    check_hit("s1");
    check("s1_idle", 256'(busy_o), 256'(0));
`ifdef RF80386_ICACHE_STATS_EN
    check("s1_miss_count", 256'(miss_count_o), 256'(1));
    check("s1_fill_count", 256'(fill_count_o), 256'(2));
`endif

    // 2: misaligned fetch within a filled pair, then zero-latency hits.
    set_csip(32'h0000_1007);
    #1;
    check("s2_cold_ihit", 256'(ihit), 256'(0));
    exp_adr_q.push_back(32'h0000_1000);
    exp_adr_q.push_back(32'h0000_1010);
    fill_one("s2a");
    fill_one("s2b");
    check("s2_byte0", 256'(ibundle[7:0]), 256'(8'h07));
    check_hit("s2");
    set_csip(32'h0000_1000);
    check_hit("s2_off0");
    set_csip(32'h0000_1009);
    check_hit("s2_off9");

    // 3: top-of-memory wrap.
    set_csip(32'hFFFF_FFF8);
    exp_adr_q.push_back(32'h0000_0000);
    exp_adr_q.push_back(32'hFFFF_FFF0);
    fill_one("s3a");
    fill_one("s3b");
    check("s3_low8", 256'(ibundle[63:0]), 256'(line_data(32'hFFFF_FFF0) >> 64));
    check_hit("s3");

    // 4: retry, timed reissue, stale ack ignored.
    set_csip(32'h0000_2000);
    wait_req(found);
    check("s4_adr0", 256'(ftam_req.adr), 256'(32'h0000_2000));
    check("s4_tid0", 256'(ftam_req.tid.tranid), 256'(exp_tid));
    t1 = ftam_req.tid.tranid;
    exp_tid = (exp_tid == 4'd15) ? 4'd1 : exp_tid + 4'd1;
    tick();
    drive_resp(1'b0, 1'b1, t1, '0);
    rty_cyc = cyc_cnt;
    tick();
    drive_resp(1'b0, 1'b0, 4'd0, '0);
    drive_resp(1'b1, 1'b0, t1, ~line_data(32'h0000_2000));
    tick();
    drive_resp(1'b0, 1'b0, 4'd0, '0);
    wait_req(found);
    check("s4_retry_delay", 256'(cyc_cnt - rty_cyc), 256'(RTY_WAIT + 1));
    check("s4_adr1", 256'(ftam_req.adr), 256'(32'h0000_2000));
    check("s4_tid1", 256'(ftam_req.tid.tranid), 256'(exp_tid));
    t2 = ftam_req.tid.tranid;
    exp_tid = (exp_tid == 4'd15) ? 4'd1 : exp_tid + 4'd1;
    tick();
    drive_resp(1'b1, 1'b0, t1, ~line_data(32'h0000_2000));
    tick();
    drive_resp(1'b0, 1'b0, 4'd0, '0);
    #1;
    check("s4_stale_ignored", 256'({busy_o, ftam_req.cyc}), 256'(2'b10));
    drive_resp(1'b1, 1'b0, t2, line_data(32'h0000_2000));
    tick();
    drive_resp(1'b0, 1'b0, 4'd0, '0);
    exp_adr_q.push_back(32'h0000_2010);
    fill_one("s4b");
    check_hit("s4");

    // 5: invalidate during an outstanding fill.
    set_csip(32'h0000_3000);
    wait_req(found);
    check("s5_adr0", 256'(ftam_req.adr), 256'(32'h0000_3000));
    t1 = ftam_req.tid.tranid;
    exp_tid = (exp_tid == 4'd15) ? 4'd1 : exp_tid + 4'd1;
    tick();
    inv_i = 1'b1;
    #1;
    check("s5_inv_ihit", 256'(ihit), 256'(0));
    tick();
    inv_i = 1'b0;
    drive_resp(1'b1, 1'b0, t1, line_data(32'h0000_3000));
    tick();
    drive_resp(1'b0, 1'b0, 4'd0, '0);
    #1;
    check("s5_discard_idle", 256'({ihit, busy_o, ftam_req.cyc}), 256'(3'b000));
    exp_adr_q.push_back(32'h0000_3000);
    exp_adr_q.push_back(32'h0000_3010);
    fill_one("s5a");
    check("s5_half_ihit", 256'(ihit), 256'(0));
    fill_one("s5b");
    check_hit("s5");

    // 6: more misses to roll the transaction id past 15.
    for (int i = 0; i < 4; i++) begin
      set_csip(32'h0000_4000 + 32'(i * 32 + i));
      exp_adr_q.push_back(32'h0000_4000 + 32'(i * 32));
      exp_adr_q.push_back(32'h0000_4010 + 32'(i * 32));
      fill_one("s6a");
      fill_one("s6b");
      check_hit("s6");
    end

    // 7: reset mid-fill; the late ack must not count.
    set_csip(32'h0000_5000);
    wait_req(found);
    t1 = ftam_req.tid.tranid;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check("s7_rst_busy", 256'({busy_o, ihit}), 256'(2'b00));
    exp_tid = 4'd1;
    drive_resp(1'b1, 1'b0, t1, ~line_data(32'h0000_5000));
    tick();
    drive_resp(1'b0, 1'b0, 4'd0, '0);
    exp_adr_q.push_back(32'h0000_5000);
    exp_adr_q.push_back(32'h0000_5010);
    fill_one("s7a");
    fill_one("s7b");
    check_hit("s7");
    check("s7_sb_drained", 256'(exp_adr_q.size() + exp_bun_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf80386_icache.md
# rf80386_icache

Two-bank, direct-mapped, line-pair instruction cache that sits directly upstream of the rf80386 core. It takes the core's linear fetch address `csip` and returns `ibundle`: 16 consecutive code bytes starting at `csip`, at any byte alignment. It also returns `ihit`. Misses are filled over a private fta bus master port, a second channel beside the core's data port.

## Interface
Parameters:
- CORENO, 6'd1: core number placed in `ftam_req.tid.core`.
- CID, 3'd2: channel id placed in `ftam_req.tid.channel`.
- LINES_PER_BANK, 32: lines per bank; must be a power of two, minimum 2.
- RTY_WAIT, 5'd16: cycles to wait after `rty` before a request is reissued.

Ports:
- clk_i, in, 1: the single clock.
- rst_i, in, 1: reset, synchronous, active-high.
- csip, in, 32: linear fetch address from the core.
- ibundle, out, 128: code bytes `csip`..`csip+15`, with byte 0 in bits [7:0].
- ihit, out, 1: `ibundle` is valid this cycle.
- inv_i, in, 1: invalidate all lines; single-cycle pulse.
- busy_o, out, 1: FSM not IDLE.
- ftam_req, out, fta_cmd_request128_t: fill request.
- ftam_resp, in, fta_cmd_response128_t: fill response.

## Operation
Address decode:
- Line address is `A = csip[31:4]`.
- A bundle spans lines A and A+1, computed modulo 2^28 so it wraps at 0xFFFFFFF0.
- Even bank holds lines with bit 0 = 0; odd bank holds lines with bit 0 = 1.
- Bank index is `line[log2(LINES_PER_BANK):1]`. Tag is the remaining upper line bits.

Lookup (combinational, LUT-RAM read):
- `lo` = data of line A; `hi` = data of line A+1, each taken from its own bank.
- `ibundle = ({hi,lo} >> {csip[3:0],3'd0})[127:0]`.
- `ihit` = both lines valid, tags match, and `inv_i` low.
- When `ihit` is 0, `ibundle` is don't-care. The core treats it as a miss.

FSM states:
- **IDLE**
  - `ihit` = 0 → latch the missing line addresses (even line first, then odd) → REQ.
  - If only one line misses, only that line is fetched.
- **REQ**
  - Drive one cycle of: `cmd` = CMD_LOAD, `cyc` = `stb` = 1, `we` = 0, `sel` = 16'hFFFF, `adr` = `{line,4'h0}`, and a new tranid → WAIT.
  - tranid rolls 1..15 and skips 0.
- **WAIT**
  - `ack` with matching tranid → write `dat` into the bank. Set valid and tag, unless the `discard` flag is set.
  - If a second line is pending → REQ for it; otherwise → IDLE.
  - `rty` with matching tranid → RETRY.
- **RETRY**
  - Count RTY_WAIT cycles, then → REQ for the same line.

Edge cases:
- Outside REQ, `ftam_req` is cleared: `cmd` = CMD_NONE, `cyc`/`stb`/`we` = 0, `sel` = 0, tranid 0.
- Responses with a non-matching tranid are ignored.
- `csip` may change during a fill. The fill in progress still completes and is written. On return to IDLE, the lookup re-evaluates the new `csip`.
- `inv_i` clears every valid bit the same cycle. If a fill is outstanding, set `discard`; that line's `ack` is consumed but not marked valid. A pending second line is dropped, and the FSM returns to IDLE.
- `inv_i` and a fill-write in the same cycle: the invalidate wins.

## Timing
- Reset:
  - All valid bits 0; `ihit` 0; `busy_o` 0.
  - FSM in IDLE; tid = 1; `discard` = 0.
  - `ftam_req` all zero except `tid.core` = CORENO and `tid.channel` = CID.
- Hit latency is 0 cycles: `ihit` and `ibundle` follow `csip` combinationally.
- Miss timing:
  - The request is on the bus the cycle after IDLE detects the miss.
  - `ihit` rises the cycle after the last `ack` is written.
- Single-line miss penalty is 2 + memory latency. A two-line miss is twice that.
- Reset asserted mid-fill aborts the fill. A late `ack` arriving after reset is ignored because its tranid no longer matches.

## Configuration
- `RF80386_ICACHE_STATS_EN` defined:
  - Adds outputs `miss_count_o[31:0]` and `fill_count_o[31:0]`. Both reset to 0 and wrap at 2^32.
  - `miss_count_o` increments on each IDLE→REQ transition.
  - `fill_count_o` increments on each accepted `ack`, including discarded ones.
- Macro undefined: the ports and counters are absent.

## Structure
- In `rf80386_pkg`:
  - `icache_state_t` (IDLE, REQ, WAIT, RETRY).
  - `ICACHE_LINE_BYTES` = 16.
- fta bus types come from `fta_bus_pkg`.
- One sub-module: `rf80386_icache_bank`, a valid/tag/data array with one asynchronous read port and one synchronous write port plus clear-all. It is instantiated twice, once as the even bank and once as the odd bank.

## Test plan
1. Reset, `csip` = 0x000FFFF0:
   - `ihit` = 0.
   - Requests issued in order: `adr` 0x00100000 (even line), then 0x000FFFF0.
   - After both `ack`s, `ihit` = 1, and `ibundle[7:0]` equals byte 0 of the 0xFFFF0 line.
2. Lines 0x1000/0x1010 filled with bytes 0x00..0x1F, `csip` = 0x1007:
   - `ibundle` = bytes 0x07..0x16, with `ibundle[7:0]` = 0x07.
   - `ihit` = 1 in the same cycle.
3. `csip` = 0xFFFFFFF8, cold cache:
   - Fetches go to 0x00000000 and 0xFFFFFFF0 (wrap).
   - Then `ihit` = 1 with bytes 8..15 of the top line in `ibundle[63:0]`.
4. First request answered with `rty`:
   - The same `adr` is reissued exactly RTY_WAIT+1 cycles later with a new tranid.
   - A stray `ack` carrying a stale tranid is ignored.
5. `inv_i` pulsed while WAIT holds an outstanding fill:
   - The following `ack` does not set valid.
   - FSM returns to IDLE and immediately re-requests the line.
   - `ihit` stays 0 until that refetch completes.
6. With `RF80386_ICACHE_STATS_EN`: after scenario 1, `miss_count_o` = 1 and `fill_count_o` = 2.
